dff_pipe_clr: RTL and testbench
===============================

DFF_PIPE_CLR -- requirements
Module: dff_pipe_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data path width in bits, legal range >= 1.
REQ-002 SHALL have parameter DEPTH, default 3: number of register stages, legal range >= 1.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; clock port is Clk, reset port is _Reset.
REQ-004 Port Clk, input, 1: rising-edge clock for all state.
REQ-005 Port _Reset, input, 1: asynchronous active-low reset of all state.
REQ-006 Port _Clr, input, 1: synchronous active-low clear (flush), sampled on rising Clk.
REQ-007 Port In_Valid, input, 1: D holds a word to enter the pipeline.
REQ-008 Port In_Ready, output, 1: pipeline accepts a word this cycle.
REQ-009 Port D, input, WIDTH: input data word.
REQ-010 Port Out_Valid, output, 1: Q holds a valid word.
REQ-011 Port Out_Ready, input, 1: downstream accepts Q this cycle.
REQ-012 Port Q, output, WIDTH: output data word, taken directly from the last stage register.
REQ-013 Port Occupancy, output, clog2(DEPTH+1) (minimum 1): count of valid stages.

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) a valid bit v[i] and a data register d[i]; stage DEPTH-1 drives Q and Out_Valid.
REQ-015 SHALL compute readiness combinationally: rdy[DEPTH-1] = Out_Ready OR NOT v[DEPTH-1]; rdy[i] = rdy[i+1] OR NOT v[i].
REQ-016 SHALL drive In_Ready = rdy[0] AND _Clr.
REQ-017 SHALL load stage 0 on the rising edge when In_Valid AND In_Ready: d[0] <= D, v[0] <= 1.
REQ-018 SHALL move stage i-1 into stage i when v[i-1] AND rdy[i]: d[i] <= d[i-1], v[i] <= 1.
REQ-019 SHALL clear v[i] on the edge where stage i hands off its word and receives no new word.
REQ-020 SHALL consume the output word when Out_Valid AND Out_Ready.
REQ-021 SHALL hold d[i] unchanged whenever stage i does not load; no data register toggles on a stalled stage.
REQ-022 SHALL collapse bubbles: an empty stage accepts from upstream even while downstream is stalled.
REQ-023 SHALL give latency DEPTH cycles from input acceptance to Out_Valid when the pipe is empty and Out_Ready=1.
REQ-024 SHALL sustain throughput of one word per cycle with Out_Ready held high.
REQ-025 SHALL hold DEPTH words with Out_Ready low; In_Ready=0 when full.
REQ-026 Full with simultaneous Out_Ready=1: In_Ready=1; accept and emit in the same cycle; Occupancy unchanged.
REQ-027 SHALL not alter state when In_Valid=1 and In_Ready=0; the word is not taken and the upstream source holds it.
REQ-028 _Clr=0 at an edge: all v[i] <= 0 and all d[i] <= 0, overriding every transfer in that cycle.
REQ-029 _Clr=0: no input is accepted; an output word presented in that cycle is discarded.
REQ-030 SHALL drive Occupancy as the registered population count of v[], updated on the same edge as v[].
REQ-031 DEPTH=1: SHALL behave as a single skid-free register with the same handshake rules.

Reset
REQ-032 _Reset low SHALL immediately, without a clock, force all v[i]=0 and d[i]=0.
REQ-033 While _Reset is low, outputs SHALL be Out_Valid=0, Q=0, Occupancy=0, and In_Ready=_Clr.
REQ-034 _Reset deassertion SHALL take effect on the first Clk edge at which _Reset samples high; reset mid-transfer discards all words.

Verification
REQ-035 Fill/drain (WIDTH=8, DEPTH=3): Out_Ready=1; push 0x11, 0x22, 0x33 on consecutive cycles -> Q=0x11 with Out_Valid=1 three cycles after the first accept, then 0x22 and 0x33 on the next two cycles.
REQ-036 Backpressure: Out_Ready=0; push 4 words -> first 3 accepted, Occupancy=3, In_Ready=0, 4th word held; raise Out_Ready -> words appear in order with no loss or duplication.
REQ-037 Bubble collapse: v=1,0,1 with Out_Ready=0; push a word -> v becomes 1,1,1 in one cycle and d[2] is unchanged.
REQ-038 Full plus simultaneous accept/emit: full pipe with Out_Ready=1 and In_Valid=1 -> one word out, one word in, Occupancy stays 3.
REQ-039 Sync clear: full pipe; _Clr=0 for one edge with In_Valid=1 -> Occupancy=0, Q=0, Out_Valid=0, input word not taken.
REQ-040 Async reset: assert _Reset between clock edges while full -> Out_Valid, Q and Occupancy drop to 0 before the next edge; after release, normal fill resumes.

Source files
------------

// File: rtl/dff_pipe_clr.sv
// Elastic register pipeline with valid/ready handshake, bubble collapse and a
// synchronous active-low flush. Each stage holds one word; Q comes straight from the last stage.

module dff_pipe_clr_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] din,
    output logic             vld,
    output logic [WIDTH-1:0] dout
);
    // Data only moves on load, so a stalled stage never toggles its register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (!clr_n) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (unload) begin
            vld  <= 1'b0;
        end
    end
endmodule

module dff_pipe_clr #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int OCC_W = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             _Reset,
    input  logic             _Clr,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] D,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Q,
    output logic [OCC_W-1:0] Occupancy
);
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            unload;
    logic [DEPTH-1:0][WIDTH-1:0] data;

    // Ready ripples from the output back toward the input; an empty stage is
    // always ready, which is what lets bubbles collapse under backpressure.
    always_comb begin
        rdy    = '0;
        load   = '0;
        unload = '0;
        rdy[DEPTH-1] = Out_Ready | ~vld[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--)
            rdy[i] = rdy[i+1] | ~vld[i];
        In_Ready = rdy[0] & _Clr;
        load[0]  = In_Valid & In_Ready;
        for (int i = 1; i < DEPTH; i++)
            load[i] = vld[i-1] & rdy[i];
        for (int i = 0; i < DEPTH - 1; i++)
            unload[i] = load[i+1];
        unload[DEPTH-1] = vld[DEPTH-1] & Out_Ready;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
        if (i == 0) begin : g_head
            assign din = D;
        end else begin : g_body
            assign din = data[i-1];
        end
        dff_pipe_clr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (Clk),
            .rst_n  (_Reset),
            .clr_n  (_Clr),
            .load   (load[i]),
            .unload (unload[i]),
            .din    (din),
            .vld    (vld[i]),
            .dout   (data[i])
        );
    end

    assign Q         = data[DEPTH-1];
    assign Out_Valid = vld[DEPTH-1];

    // Words enter only at stage 0 and leave only at the last stage, so this
    // counter stays equal to the population count of vld on every edge.
    always_ff @(posedge Clk or negedge _Reset) begin
        if (!_Reset)
            Occupancy <= '0;
        else if (!_Clr)
            Occupancy <= '0;
        else
            Occupancy <= Occupancy + OCC_W'(load[0]) - OCC_W'(unload[DEPTH-1]);
    end
endmodule

// File: tb/tb_dff_pipe_clr.sv
// Directed bench: driver pushes accepted words into a scoreboard queue, a
// negedge monitor pops and compares every word the pipeline hands downstream.
module tb_dff_pipe_clr;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             Clk = 1'b0;
    logic             _Reset = 1'b0;
    logic             _Clr = 1'b1;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [WIDTH-1:0] D = '0;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
    logic [WIDTH-1:0] Q;
    logic [1:0]       Occupancy;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb[$];

    dff_pipe_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), ._Reset(_Reset), ._Clr(_Clr),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .D(D),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Q(Q),
        .Occupancy(Occupancy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Present a word and hold it until the pipeline takes it (bounded).
    task automatic push(input logic [WIDTH-1:0] w);
        bit taken = 0;
        In_Valid = 1'b1;
        D        = w;
        for (int k = 0; k < 20 && !taken; k++) begin
            @(negedge Clk);
            if (In_Ready) begin
                sb.push_back(w);
                taken = 1;
            end
            cyc();
        end
        if (!taken) chk("push_timeout", 0, 1);
    endtask

    always @(negedge Clk) begin
        if (_Reset && _Clr && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) chk("sb_unexpected", {24'h0, Q}, 32'hDEAD);
            else chk("sb_data", {24'h0, Q}, {24'h0, sb.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_q", Q, 0);
        chk("rst_occ", Occupancy, 0);
        chk("rst_in_ready", In_Ready, 1);
        #4 _Reset = 1'b1;
        cyc();

        // Fill/drain: latency and streaming order
        Out_Ready = 1'b1;
        push(8'h11);
        chk("fill_lat1", Out_Valid, 0);
        push(8'h22);
        chk("fill_lat2", Out_Valid, 0);
        push(8'h33);
        chk("fill_lat3_valid", Out_Valid, 1);
        chk("fill_lat3_q", Q, 8'h11);
        In_Valid = 1'b0;
        repeat (4) cyc();
        chk("fill_drained_occ", Occupancy, 0);

        // Backpressure: 3 fit, 4th is held until downstream opens
        Out_Ready = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        chk("bp_occ_full", Occupancy, 3);
        chk("bp_in_ready", In_Ready, 0);
        In_Valid = 1'b1;
        D        = 8'hA4;
        repeat (2) cyc();
        chk("bp_held_occ", Occupancy, 3);
        chk("bp_held_q", Q, 8'hA1);
        chk("bp_held_ready", In_Ready, 0);
        // Full with Out_Ready=1: simultaneous accept and emit
        Out_Ready = 1'b1;
        #1 chk("full_pass_ready", In_Ready, 1);
        push(8'hA4);
        chk("full_pass_occ", Occupancy, 3);
        chk("full_pass_q", Q, 8'hA2);
        In_Valid = 1'b0;
        repeat (5) cyc();
        chk("bp_drained_occ", Occupancy, 0);

        // Bubble collapse: build v = 1,0,1 then push one more word
        Out_Ready = 1'b0;
        push(8'hB1);
        In_Valid = 1'b0;
        repeat (2) cyc();
        chk("bub_occ1", Occupancy, 1);
        push(8'hB2);
        chk("bub_occ2", Occupancy, 2);
        chk("bub_q_before", Q, 8'hB1);
        push(8'hB3);
        In_Valid = 1'b0;
        chk("bub_occ3", Occupancy, 3);
        chk("bub_q_after", Q, 8'hB1);
        chk("bub_full_ready", In_Ready, 0);

        // Synchronous clear while full, with an input word offered
        In_Valid  = 1'b1;
        D         = 8'hCC;
        Out_Ready = 1'b1;
        _Clr      = 1'b0;
        #1 chk("clr_in_ready", In_Ready, 0);
        cyc();
        sb.delete();
        _Clr     = 1'b1;
        In_Valid = 1'b0;
        chk("clr_occ", Occupancy, 0);
        chk("clr_q", Q, 0);
        chk("clr_out_valid", Out_Valid, 0);
        repeat (3) cyc();
        chk("clr_not_taken", Out_Valid, 0);

        // Asynchronous reset mid-cycle while full
        Out_Ready = 1'b0;
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        In_Valid = 1'b0;
        chk("ar_full_occ", Occupancy, 3);
        #1 _Reset = 1'b0;
        #1;
        chk("ar_out_valid", Out_Valid, 0);
        chk("ar_q", Q, 0);
        chk("ar_occ", Occupancy, 0);
        chk("ar_in_ready", In_Ready, 1);
        sb.delete();
        #3 _Reset = 1'b1;
        cyc();
        Out_Ready = 1'b1;
        push(8'hE1);
        push(8'hE2);
        In_Valid = 1'b0;
        repeat (6) cyc();
        chk("ar_resume_occ", Occupancy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
